inst_prefetch_queue: RTL

Parametrised instruction fetch front end with multiple outstanding requests. It replaces the single-request fetch stage between the SRAM-like instruction port and decode. It keeps up to MAX_OUTSTANDING requests in flight and buffers returned instructions in a DEPTH-entry queue. On redirect (branch, exception, eret) it discards stale in-flight responses, and it reports AdEL for misaligned fetch PCs.

---
 rtl/inst_prefetch_queue_pkg.sv | 11 +
 rtl/inst_prefetch_queue_fetch_fifo.sv | 42 ++++
 rtl/inst_prefetch_queue.sv | 83 ++++++++
 3 files changed

// File: rtl/inst_prefetch_queue_pkg.sv
// inst_prefetch_queue_pkg: reset vector, fetch exception code and queue entry layout
package inst_prefetch_queue_pkg;
  localparam logic [31:0] VEC_RESET = 32'hbfc00000;
  localparam logic [4:0] EXC_ADEL_CODE = 5'h04;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic exc;
    logic [4:0] exccode;
  } fetch_entry_t;
endpackage

// File: rtl/inst_prefetch_queue_fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, registered storage and occupancy count
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign do_pop = pop && count != '0;
  assign do_push = push && (count != CW'(DEPTH) || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr] <= din;
endmodule

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: multi-outstanding instruction fetch front end with redirect discard and AdEL
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC = VEC_RESET,
  parameter logic [4:0]  EXC_ADEL = EXC_ADEL_CODE
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_rdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic        cancel_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        exc_o,
  output logic [4:0]  exccode_o,
  input  logic        ready_i
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0] pc, hold_addr, pcf_head;
  logic halted, hold, hold_stale;
  logic [OW-1:0] outstanding, outstanding_nxt, discard_cnt, pcf_count;
  logic [CW-1:0] occupancy;
  logic fresh, acc, live, drop, keep, adel, q_push, q_pop;
  fetch_entry_t q_din, q_dout;
  assign fresh = !halted && !cancel_i && pc[1:0] == 2'b00 &&
                 32'(outstanding) < MAX_OUTSTANDING &&
                 32'(occupancy) + 32'(outstanding) < DEPTH;
  assign inst_req = resetn && (hold || fresh);
  assign inst_addr = hold ? hold_addr : pc;
  assign acc = inst_req && inst_addr_ok;
  assign live = !(hold && hold_stale);
  assign drop = discard_cnt != '0;
  assign keep = inst_data_ok && !drop;
  // AdEL is raised only once all live fetches ahead of it have landed
  assign adel = !halted && !hold && !cancel_i && pc[1:0] != 2'b00 &&
                pcf_count == '0 && 32'(occupancy) < DEPTH;
  assign q_push = !cancel_i && (keep || adel);
  assign q_pop = valid_o && ready_i && !cancel_i;
  assign q_din = adel ? fetch_entry_t'{pc: pc, inst: 32'h0, exc: 1'b1, exccode: EXC_ADEL}
                      : fetch_entry_t'{pc: pcf_head, inst: inst_rdata, exc: 1'b0, exccode: 5'h0};
  assign outstanding_nxt = outstanding + OW'(acc) - OW'(inst_data_ok);
  assign valid_o = occupancy != '0;
  assign pc_o = q_dout.pc;
  assign inst_o = q_dout.inst;
  assign exc_o = q_dout.exc;
  assign exccode_o = q_dout.exccode;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      pc <= RESET_PC;
      halted <= 1'b0;
      hold <= 1'b0;
      hold_stale <= 1'b0;
      hold_addr <= '0;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      hold <= inst_req && !inst_addr_ok;
      hold_stale <= inst_req && !inst_addr_ok && (hold_stale || cancel_i);
      hold_addr <= inst_addr;
      discard_cnt <= cancel_i ? outstanding_nxt
                              : discard_cnt + OW'(acc && !live) - OW'(inst_data_ok && drop);
      pc <= cancel_i ? redirect_pc_i : (acc && live) ? pc + 32'd4 : pc;
      halted <= !cancel_i && (halted || adel);
    end
  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_queue (
    .clk(clk), .resetn(resetn), .flush(cancel_i), .push(q_push), .pop(q_pop),
    .din(q_din), .dout(q_dout), .count(occupancy)
  );
  fetch_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_pc_fifo (
    .clk(clk), .resetn(resetn), .flush(cancel_i), .push(acc && live), .pop(keep),
    .din(inst_addr), .dout(pcf_head), .count(pcf_count)
  );
endmodule
